// File: rtl/fpu_vfloat_dispatch.sv
// VFloat FPU issue/retire stage: multi-outstanding issue to add/mul/div/sqrt
// units, per-unit slot FIFOs, in-order retirement through a reorder buffer.
//
// Ports:
//   clk, reset (async, active-low)
//   CPU request : in_valid, fpu_ready, operator, rounding_mode, tag, inOp1, inOp2
//   CPU result  : result_valid, cpu_ready, tag_out, result, exception
//   status      : occupancy, protocol_err (sticky)
//   unit issue  : start_add/mul/div/sqrt, op_a, op_b, vfloat_round
//   unit return : done_*, y_*, exc_*
module fpu_vfloat_dispatch #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  parameter logic [2:0] OP_ADD = 3'd0,
  parameter logic [2:0] OP_SUB = 3'd1,
  parameter logic [2:0] OP_MUL = 3'd2,
  parameter logic [2:0] OP_DIV = 3'd3,
  parameter logic [2:0] OP_SQRT = 3'd4,
  localparam int IEEE_W = 1 + EXP_WIDTH + MAN_WIDTH,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              fpu_ready,
  input  logic [2:0]        operator,
  input  logic [2:0]        rounding_mode,
  input  logic [TAG_W-1:0]  tag,
  input  logic [IEEE_W-1:0] inOp1,
  input  logic [IEEE_W-1:0] inOp2,
  output logic              result_valid,
  input  logic              cpu_ready,
  output logic [TAG_W-1:0]  tag_out,
  output logic [IEEE_W-1:0] result,
  output logic              exception,
  output logic [CW-1:0]     occupancy,
  output logic              protocol_err,
  output logic              start_add,
  output logic              start_mul,
  output logic              start_div,
  output logic              start_sqrt,
  output logic [IEEE_W-1:0] op_a,
  output logic [IEEE_W-1:0] op_b,
  output logic              vfloat_round,
  input  logic              done_add,
  input  logic              done_mul,
  input  logic              done_div,
  input  logic              done_sqrt,
  input  logic [IEEE_W-1:0] y_add,
  input  logic [IEEE_W-1:0] y_mul,
  input  logic [IEEE_W-1:0] y_div,
  input  logic [IEEE_W-1:0] y_sqrt,
  input  logic              exc_add,
  input  logic              exc_mul,
  input  logic              exc_div,
  input  logic              exc_sqrt
);

  localparam logic [IEEE_W-1:0] QNAN =
    {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MAN_WIDTH-1){1'b0}}};
  localparam int NU = 4;

  // ROB storage
  logic [TAG_W-1:0]  rob_tag  [DEPTH];
  logic [IEEE_W-1:0] rob_res  [DEPTH];
  logic              rob_exc  [DEPTH];
  logic              rob_done [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [CW-1:0]     count;

  // per-unit slot FIFOs: unit index 0=add 1=mul 2=div 3=sqrt
  logic [PW-1:0] f_mem  [NU][DEPTH];
  logic [PW-1:0] f_wr   [NU];
  logic [PW-1:0] f_rd   [NU];
  logic [CW-1:0] f_cnt  [NU];
  logic [PW-1:0] f_slot [NU];

  logic [NU-1:0]     done_v;
  logic [IEEE_W-1:0] y_v [NU];
  logic [NU-1:0]     exc_v;
  logic [NU-1:0]     pop_v;
  logic [NU-1:0]     push_v;
  logic [NU-1:0]     issue_vec;
  logic              illegal;
  logic              accept;
  logic              retire;
  logic [IEEE_W-1:0] op_b_next;

  assign done_v = {done_sqrt, done_div, done_mul, done_add};
  assign exc_v  = {exc_sqrt, exc_div, exc_mul, exc_add};
  assign y_v[0] = y_add;
  assign y_v[1] = y_mul;
  assign y_v[2] = y_div;
  assign y_v[3] = y_sqrt;

  always_comb begin
    issue_vec = '0;
    illegal = 1'b0;
    unique case (1'b1)
      (operator == OP_ADD),
      (operator == OP_SUB):  issue_vec[0] = 1'b1;
      (operator == OP_MUL):  issue_vec[1] = 1'b1;
      (operator == OP_DIV):  issue_vec[2] = 1'b1;
      (operator == OP_SQRT): issue_vec[3] = 1'b1;
      default:               illegal = 1'b1;
    endcase
  end

  assign op_b_next = (operator == OP_SUB)
    ? {~inOp2[IEEE_W-1], inOp2[IEEE_W-2:0]}
    : inOp2;

  // no full-bypass: a same-cycle retire does not open a slot
  assign fpu_ready = (count < CW'(DEPTH));
  assign accept = in_valid & fpu_ready;

  assign result_valid = (count != '0) & rob_done[head];
  assign retire = result_valid & cpu_ready;
  assign tag_out = rob_tag[head];
  assign result = rob_res[head];
  assign exception = rob_exc[head];
  assign occupancy = count;

  always_comb begin
    for (int u = 0; u < NU; u++) begin
      f_slot[u] = f_mem[u][f_rd[u]];
      pop_v[u] = done_v[u] & (f_cnt[u] != '0);
      push_v[u] = accept & issue_vec[u];
    end
  end

  // slot FIFOs: remember which ROB slot each unit op belongs to
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int u = 0; u < NU; u++) begin
        f_wr[u] <= '0;
        f_rd[u] <= '0;
        f_cnt[u] <= '0;
        for (int i = 0; i < DEPTH; i++)
          f_mem[u][i] <= '0;
      end
    end else begin
      for (int u = 0; u < NU; u++) begin
        if (push_v[u]) begin
          f_mem[u][f_wr[u]] <= tail;
          f_wr[u] <= f_wr[u] + 1'b1;
        end
        if (pop_v[u])
          f_rd[u] <= f_rd[u] + 1'b1;
        f_cnt[u] <= f_cnt[u] + CW'(push_v[u])
                    - CW'(pop_v[u]);
      end
    end
  end

  // reorder buffer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_tag[i] <= '0;
        rob_res[i] <= '0;
        rob_exc[i] <= 1'b0;
        rob_done[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        rob_tag[tail] <= tag;
        rob_res[tail] <= illegal ? QNAN : '0;
        rob_exc[tail] <= illegal;
        rob_done[tail] <= illegal;
        tail <= tail + 1'b1;
      end
      // live slots only; never collides with the tail write
      for (int u = 0; u < NU; u++) begin
        if (pop_v[u]) begin
          rob_res[f_slot[u]] <= y_v[u];
          rob_exc[f_slot[u]] <= exc_v[u];
          rob_done[f_slot[u]] <= 1'b1;
        end
      end
      if (|(done_v & ~pop_v))
        protocol_err <= 1'b1;
      if (retire)
        head <= head + 1'b1;
      count <= count + CW'(accept) - CW'(retire);
    end
  end

  // issue registers: one-cycle start pulse, operands held until next issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_add <= 1'b0;
      start_mul <= 1'b0;
      start_div <= 1'b0;
      start_sqrt <= 1'b0;
      op_a <= '0;
      op_b <= '0;
      vfloat_round <= 1'b0;
    end else begin
      start_add <= push_v[0];
      start_mul <= push_v[1];
      start_div <= push_v[2];
      start_sqrt <= push_v[3];
      if (|push_v) begin
        op_a <= inOp1;
        op_b <= op_b_next;
        vfloat_round <= (rounding_mode == 3'd0);
      end
    end
  end

endmodule

// File: doc/fpu_vfloat_dispatch.md
# fpu_vfloat_dispatch

Multi-outstanding issue and in-order retirement stage for the VFloat FPU datapath. It sits between the CPU-side FPU handshake and the four VFloat arithmetic units (add/sub, mul, div, sqrt). It accepts up to DEPTH operations in flight across units with different latencies. It retires results strictly in acceptance order through a reorder buffer (ROB). It replaces the single-operation controller, which blocks on every operation.

## Interface
Parameters:
- EXP_WIDTH, 8, exponent width; IEEE_W = 1+EXP_WIDTH+MAN_WIDTH (localparam)
- MAN_WIDTH, 23, mantissa width
- DEPTH, 4, ROB entries; power of two, ≥2; also the depth of each per-unit slot FIFO
- TAG_W, 4, tag width
- OP_ADD/OP_SUB/OP_MUL/OP_DIV/OP_SQRT, 3'd0/1/2/3/4, operator encodings

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low; clears all state
- in_valid  in  1  request valid
- fpu_ready  out  1  request accepted when in_valid & fpu_ready
- operator  in  3  opcode
- rounding_mode  in  3  0 = round-nearest-even, other values = truncate
- tag  in  TAG_W  request tag
- inOp1, inOp2  in  IEEE_W  operands (inOp2 ignored for SQRT)
- result_valid  out  1  ROB head complete
- cpu_ready  in  1  consumer accepts result
- tag_out  out  TAG_W  tag of retiring op
- result  out  IEEE_W  result of retiring op
- exception  out  1  exception of retiring op
- occupancy  out  $clog2(DEPTH)+1  live ROB entries
- protocol_err  out  1  sticky: a unit pulsed done with no outstanding slot
- start_add, start_mul, start_div, start_sqrt  out  1  one-cycle issue pulses
- op_a, op_b  out  IEEE_W  issued operands (op_b sign already flipped for SUB)
- vfloat_round  out  1  1 = RNE, 0 = truncate; valid with start_*
- done_add, done_mul, done_div, done_sqrt  in  1  unit completion pulses
- y_add, y_mul, y_div, y_sqrt  in  IEEE_W  unit results, valid with done_*
- exc_add, exc_mul, exc_div, exc_sqrt  in  1  unit exceptions, valid with done_*

## Operation
- ROB: circular buffer, head/tail pointers of $clog2(DEPTH) bits wrapping modulo DEPTH, plus a count. Each entry holds {tag, result, exc, done}.
- Accept (in_valid & fpu_ready): write the tag at tail and clear done; tail++, count++.
- Unit ops: register a one-cycle start_<unit>, op_a, op_b and vfloat_round. Push the tail slot index into that unit's slot FIFO.
  - ADD/SUB both use start_add.
  - SUB issues op_b = {~inOp2[MSB], inOp2[IEEE_W-2:0]}.
- Illegal opcode (5–7): no unit start. Entry written done at accept with result = canonical qNaN {0, all-ones exp, 1, zeros} and exc=1.
- Completion: done_X pops the head of unit X's slot FIFO and writes y_X/exc_X into that ROB slot with done=1. Different units may complete in the same cycle; all writes take effect.
- done_X with X's FIFO empty: ignored, protocol_err set (cleared only by reset).
- Retire: result_valid = count>0 & head.done. tag_out/result/exception are driven from the head entry. On result_valid & cpu_ready: head++, count--.
- fpu_ready = (count < DEPTH). A retire in the same cycle does not raise fpu_ready (no full-bypass).
- Simultaneous accept and retire: count unchanged, both pointers advance.

## Timing
- Reset values: fpu_ready=1, result_valid=0, tag_out=0, result=0, exception=0, occupancy=0, protocol_err=0, all start_*=0, op_a=op_b=0, vfloat_round=0. All FIFOs empty.
- Accept at edge N → start_* high for exactly cycle N+1 → unit done at cycle D → result_valid earliest cycle D+1 if the entry is at head.
- Illegal op accepted at edge N → result_valid earliest cycle N+1.
- Back-to-back accepts are allowed every cycle until full. Consecutive same-unit starts are permitted (units are pipelined, in-order).
- result_valid and the head fields hold stable while cpu_ready=0.
- Reset asserted mid-flight clears the ROB and FIFOs immediately. Results from ops in flight are dropped.

## Test plan
- Single ADD 1.0+2.0 (0x3F800000, 0x40000000), unit model returns 0x40400000 after 3 cycles → start_add one cycle after accept; result_valid 4 cycles after start with tag_out=tag.
- DIV tag=1 (latency 20) then ADD tag=2 (latency 3) → ADD done first but is held; retire order is tag 1 then tag 2, with correct results.
- Four accepts, cpu_ready=0 → fpu_ready=0 after the 4th accept, occupancy=4. A fifth in_valid is not accepted. Raising cpu_ready retires one per cycle.
- SUB 3.0−1.0 → op_b=0xBF800000 with start_add. Opcode 6 → result 0x7FC00000 with exception=1, retired in order, no start pulse.
- done_mul with no outstanding MUL → protocol_err=1 persists; ROB unchanged.
- Reset low with 3 ops in flight → all outputs at reset values within the same cycle. Subsequent ops retire normally with pointers restarted at 0.
